// File: rtl/scr1_mem_arbiter.sv
// SCR1 data-memory arbiter. Two masters share one slave port with round-robin arbitration.
// One transaction is outstanding at a time, issue can be pipelined, and a watchdog bounds the response wait.
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

package scr1_memif_pkg;
  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;
endpackage

module scr1_mem_arbiter
  import scr1_memif_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int TIMEOUT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m0_req,
  output logic                         m0_req_ack,
  input  logic                         m0_cmd,
  input  type_scr1_mem_width_e         m0_width,
  input  logic [`SCR1_DMEM_AWIDTH-1:0] m0_addr,
  input  logic [`SCR1_DMEM_DWIDTH-1:0] m0_wdata,
  output logic [`SCR1_DMEM_DWIDTH-1:0] m0_rdata,
  output logic [1:0]                   m0_resp,
  input  logic                         m1_req,
  output logic                         m1_req_ack,
  input  logic                         m1_cmd,
  input  type_scr1_mem_width_e         m1_width,
  input  logic [`SCR1_DMEM_AWIDTH-1:0] m1_addr,
  input  logic [`SCR1_DMEM_DWIDTH-1:0] m1_wdata,
  output logic [`SCR1_DMEM_DWIDTH-1:0] m1_rdata,
  output logic [1:0]                   m1_resp,
  output logic                         slv_req,
  input  logic                         slv_req_ack,
  output logic                         slv_cmd,
  output type_scr1_mem_width_e         slv_width,
  output logic [`SCR1_DMEM_AWIDTH-1:0] slv_addr,
  output logic [`SCR1_DMEM_DWIDTH-1:0] slv_wdata,
  input  logic [`SCR1_DMEM_DWIDTH-1:0] slv_rdata,
  input  logic [1:0]                   slv_resp,
  output logic                         timeout_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_DRAIN} state_e;

  state_e                       state;
  logic                         owner_r;
  logic                         last_r;
  logic [TIMEOUT_W-1:0]         cnt_r;

  logic                         grant;
  logic                         window;
  logic                         fire;
  logic                         accept;
  logic [1:0]                   resp_sel;
  logic [`SCR1_DMEM_DWIDTH-1:0] rdata_sel;

  // Grant 0 = M0, 1 = M1; on a tie the master that was not granted last wins.
  always_comb begin
    grant = m1_req;
    if (m0_req && m1_req) begin
      grant = ~last_r;
    end

    fire   = (TIMEOUT_CYC != 0) && (state == ST_DATA) &&
             (slv_resp == SCR1_MEM_RESP_NOTRDY) && (cnt_r == TIMEOUT_W'(TIMEOUT_CYC));
    window = (state == ST_IDLE) || ((state == ST_DATA) && (slv_resp == SCR1_MEM_RESP_RDY_OK));

    slv_req   = window & (grant ? m1_req : m0_req);
    slv_cmd   = grant ? m1_cmd   : m0_cmd;
    slv_width = grant ? m1_width : m0_width;
    slv_addr  = grant ? m1_addr  : m0_addr;
    slv_wdata = grant ? m1_wdata : m0_wdata;
    accept    = slv_req & slv_req_ack;

    m0_req_ack = ~grant & window & slv_req_ack;
    m1_req_ack =  grant & window & slv_req_ack;

    resp_sel  = SCR1_MEM_RESP_NOTRDY;
    rdata_sel = '0;
    if (state == ST_DATA) begin
      resp_sel  = fire ? SCR1_MEM_RESP_RDY_ER : slv_resp;
      rdata_sel = fire ? '0 : slv_rdata;
    end

    m0_resp   = owner_r ? SCR1_MEM_RESP_NOTRDY : resp_sel;
    m0_rdata  = owner_r ? '0 : rdata_sel;
    m1_resp   = owner_r ? resp_sel : SCR1_MEM_RESP_NOTRDY;
    m1_rdata  = owner_r ? rdata_sel : '0;
    timeout_o = fire;
  end

  // DRAIN absorbs the late response of a timed-out transaction so it never reaches a master.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      owner_r <= 1'b0;
      last_r  <= 1'b1;
      cnt_r   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state   <= ST_DATA;
            owner_r <= grant;
            last_r  <= grant;
            cnt_r   <= '0;
          end
        end
        ST_DATA: begin
          if (slv_resp == SCR1_MEM_RESP_NOTRDY) begin
            if (fire) begin
              state <= ST_DRAIN;
            end else begin
              cnt_r <= cnt_r + TIMEOUT_W'(1);
            end
          end else if ((slv_resp == SCR1_MEM_RESP_RDY_OK) && accept) begin
            owner_r <= grant;
            last_r  <= grant;
            cnt_r   <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (slv_resp != SCR1_MEM_RESP_NOTRDY) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scr1_mem_arbiter.sv
// Testbench for scr1_mem_arbiter: directed scenarios plus a randomized run.
// The randomized run is checked against a transaction-level reference model.
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

module tb_scr1_mem_arbiter;
  import scr1_memif_pkg::*;

  localparam int TO = 3;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic                         m0_req, m0_req_ack, m0_cmd;
  type_scr1_mem_width_e         m0_width;
  logic [`SCR1_DMEM_AWIDTH-1:0] m0_addr;
  logic [`SCR1_DMEM_DWIDTH-1:0] m0_wdata, m0_rdata;
  logic [1:0]                   m0_resp;
  logic                         m1_req, m1_req_ack, m1_cmd;
  type_scr1_mem_width_e         m1_width;
  logic [`SCR1_DMEM_AWIDTH-1:0] m1_addr;
  logic [`SCR1_DMEM_DWIDTH-1:0] m1_wdata, m1_rdata;
  logic [1:0]                   m1_resp;
  logic                         slv_req, slv_req_ack, slv_cmd;
  type_scr1_mem_width_e         slv_width;
  logic [`SCR1_DMEM_AWIDTH-1:0] slv_addr;
  logic [`SCR1_DMEM_DWIDTH-1:0] slv_wdata, slv_rdata;
  logic [1:0]                   slv_resp;
  logic                         timeout_o;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  scr1_mem_arbiter #(.TIMEOUT_CYC(TO), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_req_ack(m0_req_ack), .m0_cmd(m0_cmd), .m0_width(m0_width),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_resp(m0_resp),
    .m1_req(m1_req), .m1_req_ack(m1_req_ack), .m1_cmd(m1_cmd), .m1_width(m1_width),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_resp(m1_resp),
    .slv_req(slv_req), .slv_req_ack(slv_req_ack), .slv_cmd(slv_cmd), .slv_width(slv_width),
    .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_rdata(slv_rdata), .slv_resp(slv_resp),
    .timeout_o(timeout_o)
  );

  task automatic idle_inputs();
    m0_req = 0; m0_cmd = 0; m0_width = SCR1_MEM_WIDTH_WORD; m0_addr = 32'h1000; m0_wdata = 32'h0;
    m1_req = 0; m1_cmd = 0; m1_width = SCR1_MEM_WIDTH_WORD; m1_addr = 32'h2000; m1_wdata = 32'h0;
    slv_req_ack = 0; slv_rdata = 32'h0; slv_resp = SCR1_MEM_RESP_NOTRDY;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    slv_resp = SCR1_MEM_RESP_RDY_OK; slv_rdata = 32'h1234_5678;
    #4;
    tests_run++; if (m0_req_ack !== 1'b0 || m1_req_ack !== 1'b0) begin tests_failed++;
      $display("[TB] FAIL reset_req_ack: got %b%b expected 00", m0_req_ack, m1_req_ack); end
    tests_run++; if (m0_resp !== SCR1_MEM_RESP_NOTRDY || m1_resp !== SCR1_MEM_RESP_NOTRDY) begin tests_failed++;
      $display("[TB] FAIL reset_resp: got %0d/%0d expected 0/0", m0_resp, m1_resp); end
    tests_run++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin tests_failed++;
      $display("[TB] FAIL reset_rdata: got %h/%h expected 0/0", m0_rdata, m1_rdata); end
    tests_run++; if (slv_req !== 1'b0 || timeout_o !== 1'b0) begin tests_failed++;
      $display("[TB] FAIL reset_slv_req_timeout: got %b/%b expected 0/0", slv_req, timeout_o); end
    do_reset();
  endtask

  task automatic test_single();
    idle_inputs();
    m0_req = 1; m0_cmd = 0; m0_addr = 32'h0001_0010; slv_req_ack = 1;
    settle();
    tests_run++; if (m0_req_ack !== 1'b1 || m1_req_ack !== 1'b0) begin tests_failed++;
      $display("[TB] FAIL single_ack: got %b%b expected 10", m0_req_ack, m1_req_ack); end
    tests_run++; if (slv_req !== 1'b1 || slv_addr !== 32'h0001_0010 || slv_cmd !== 1'b0) begin tests_failed++;
      $display("[TB] FAIL single_slv: got req %b addr %h cmd %b expected 1 00010010 0", slv_req, slv_addr, slv_cmd); end
    tick();
    idle_inputs();
    slv_resp = SCR1_MEM_RESP_RDY_OK; slv_rdata = 32'hDEAD_BEEF;
    settle();
    tests_run++; if (m0_resp !== SCR1_MEM_RESP_RDY_OK || m0_rdata !== 32'hDEAD_BEEF) begin tests_failed++;
      $display("[TB] FAIL single_m0_resp: got %0d %h expected 1 deadbeef", m0_resp, m0_rdata); end
    tests_run++; if (m1_resp !== SCR1_MEM_RESP_NOTRDY || m1_rdata !== 32'h0) begin tests_failed++;
      $display("[TB] FAIL single_m1_resp: got %0d %h expected 0 0", m1_resp, m1_rdata); end
    tick();
    idle_inputs();
  endtask

  task automatic test_contention();
    int exp_grant [4] = '{0, 1, 0, 1};
    int owner;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      idle_inputs();
      m0_req = (k < 4); m1_req = (k < 4); slv_req_ack = 1;
      m0_addr = 32'h100 + k; m1_addr = 32'h200 + k;
      slv_resp = (k == 0) ? SCR1_MEM_RESP_NOTRDY : SCR1_MEM_RESP_RDY_OK;
      slv_rdata = 32'hA000_0000 + k;
      settle();
      if (k < 4) begin
        tests_run++;
        if (slv_addr !== (exp_grant[k] ? m1_addr : m0_addr) ||
            m0_req_ack !== (exp_grant[k] == 0) || m1_req_ack !== (exp_grant[k] == 1)) begin
          tests_failed++;
          $display("[TB] FAIL contention_grant_%0d: got addr %h ack %b%b expected master %0d", k, slv_addr, m0_req_ack, m1_req_ack, exp_grant[k]);
        end
      end
      if (k > 0) begin
        owner = exp_grant[k-1];
        tests_run++;
        if ((owner ? m1_resp : m0_resp) !== SCR1_MEM_RESP_RDY_OK || (owner ? m1_rdata : m0_rdata) !== slv_rdata ||
            (owner ? m0_resp : m1_resp) !== SCR1_MEM_RESP_NOTRDY || (owner ? m0_rdata : m1_rdata) !== 32'h0) begin
          tests_failed++;
          $display("[TB] FAIL contention_route_%0d: got m0 %0d/%h m1 %0d/%h expected owner %0d", k, m0_resp, m0_rdata, m1_resp, m1_rdata, owner);
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_pipeline();
    idle_inputs();
    m1_req = 1; m1_cmd = 1; m1_wdata = 32'hCAFE_0001; slv_req_ack = 1;
    settle();
    tests_run++; if (m1_req_ack !== 1'b1 || slv_cmd !== 1'b1 || slv_wdata !== 32'hCAFE_0001) begin tests_failed++;
      $display("[TB] FAIL pipe_m1_issue: got ack %b cmd %b wdata %h expected 1 1 cafe0001", m1_req_ack, slv_cmd, slv_wdata); end
    tick();
    idle_inputs();
    m0_req = 1; m0_addr = 32'h3000; slv_req_ack = 1; slv_resp = SCR1_MEM_RESP_RDY_OK;
    settle();
    tests_run++; if (m0_req_ack !== 1'b1 || slv_req !== 1'b1 || slv_addr !== 32'h3000) begin tests_failed++;
      $display("[TB] FAIL pipe_m0_issue: got ack %b req %b addr %h expected 1 1 3000", m0_req_ack, slv_req, slv_addr); end
    tests_run++; if (m1_resp !== SCR1_MEM_RESP_RDY_OK || m0_resp !== SCR1_MEM_RESP_NOTRDY) begin tests_failed++;
      $display("[TB] FAIL pipe_m1_resp: got m1 %0d m0 %0d expected 1 0", m1_resp, m0_resp); end
    tick();
    idle_inputs();
    slv_resp = SCR1_MEM_RESP_RDY_OK; slv_rdata = 32'h5555_AAAA;
    settle();
    tests_run++; if (m0_resp !== SCR1_MEM_RESP_RDY_OK || m0_rdata !== 32'h5555_AAAA || m1_resp !== SCR1_MEM_RESP_NOTRDY) begin tests_failed++;
      $display("[TB] FAIL pipe_owner_m0: got m0 %0d %h m1 %0d expected 1 5555aaaa 0", m0_resp, m0_rdata, m1_resp); end
    tick();
    idle_inputs();
  endtask

  task automatic test_error();
    idle_inputs();
    m0_req = 1; slv_req_ack = 1;
    tick();
    idle_inputs();
    m1_req = 1; slv_req_ack = 1; slv_resp = SCR1_MEM_RESP_RDY_ER;
    settle();
    tests_run++; if (m1_req_ack !== 1'b0 || slv_req !== 1'b0) begin tests_failed++;
      $display("[TB] FAIL error_no_issue: got ack %b req %b expected 0 0", m1_req_ack, slv_req); end
    tests_run++; if (m0_resp !== SCR1_MEM_RESP_RDY_ER) begin tests_failed++;
      $display("[TB] FAIL error_m0_resp: got %0d expected 2", m0_resp); end
    tick();
    slv_resp = SCR1_MEM_RESP_NOTRDY;
    settle();
    tests_run++; if (m1_req_ack !== 1'b1) begin tests_failed++;
      $display("[TB] FAIL error_m1_next: got %b expected 1", m1_req_ack); end
    tick();
    idle_inputs();
    slv_resp = SCR1_MEM_RESP_RDY_OK; slv_rdata = 32'h77;
    settle();
    tests_run++; if (m1_resp !== SCR1_MEM_RESP_RDY_OK || m1_rdata !== 32'h77) begin tests_failed++;
      $display("[TB] FAIL error_m1_resp: got %0d %h expected 1 77", m1_resp, m1_rdata); end
    tick();
    idle_inputs();
  endtask

  task automatic test_timeout();
    idle_inputs();
    m0_req = 1; slv_req_ack = 1;
    tick();
    idle_inputs();
    slv_rdata = 32'hBAD0_BAD0;
    for (int n = 1; n <= TO + 1; n++) begin
      settle();
      tests_run++;
      if (n <= TO && (m0_resp !== SCR1_MEM_RESP_NOTRDY || timeout_o !== 1'b0)) begin tests_failed++;
        $display("[TB] FAIL timeout_wait_%0d: got resp %0d to %b expected 0 0", n, m0_resp, timeout_o); end
      else if (n > TO && (m0_resp !== SCR1_MEM_RESP_RDY_ER || m0_rdata !== 32'h0 || timeout_o !== 1'b1)) begin tests_failed++;
        $display("[TB] FAIL timeout_fire: got resp %0d rdata %h to %b expected 2 0 1", m0_resp, m0_rdata, timeout_o); end
      tick();
    end
    m1_req = 1; slv_req_ack = 1;
    settle();
    tests_run++; if (m1_req_ack !== 1'b0 || slv_req !== 1'b0 || timeout_o !== 1'b0) begin tests_failed++;
      $display("[TB] FAIL drain_closed: got ack %b req %b to %b expected 0 0 0", m1_req_ack, slv_req, timeout_o); end
    tick();
    slv_resp = SCR1_MEM_RESP_RDY_OK;
    settle();
    tests_run++; if (m0_resp !== SCR1_MEM_RESP_NOTRDY || m1_resp !== SCR1_MEM_RESP_NOTRDY || m1_req_ack !== 1'b0) begin tests_failed++;
      $display("[TB] FAIL drain_swallow: got m0 %0d m1 %0d ack %b expected 0 0 0", m0_resp, m1_resp, m1_req_ack); end
    tick();
    slv_resp = SCR1_MEM_RESP_NOTRDY;
    settle();
    tests_run++; if (m1_req_ack !== 1'b1) begin tests_failed++;
      $display("[TB] FAIL drain_next_accept: got %b expected 1", m1_req_ack); end
    tick();
    idle_inputs();
    slv_resp = SCR1_MEM_RESP_RDY_OK;
    tick();
    idle_inputs();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    m1_req = 1; slv_req_ack = 1;
    tick();
    idle_inputs();
    slv_resp = SCR1_MEM_RESP_RDY_OK; slv_rdata = 32'h0BAD_F00D;
    #1;
    tests_run++; if (m1_resp !== SCR1_MEM_RESP_RDY_OK) begin tests_failed++;
      $display("[TB] FAIL areset_pre: got %0d expected 1", m1_resp); end
    rst = 1'b1;
    #1;
    tests_run++; if (m1_resp !== SCR1_MEM_RESP_NOTRDY || m1_rdata !== 32'h0 || m0_resp !== SCR1_MEM_RESP_NOTRDY) begin tests_failed++;
      $display("[TB] FAIL areset_now: got m1 %0d %h m0 %0d expected 0 0 0", m1_resp, m1_rdata, m0_resp); end
    tick();
    rst = 1'b0;
    settle();
    tests_run++; if (m1_resp !== SCR1_MEM_RESP_NOTRDY || m1_rdata !== 32'h0 || m0_resp !== SCR1_MEM_RESP_NOTRDY) begin tests_failed++;
      $display("[TB] FAIL areset_late_resp: got m1 %0d %h m0 %0d expected 0 0 0", m1_resp, m1_rdata, m0_resp); end
    tick();
    idle_inputs();
    m0_req = 1; m1_req = 1;
    settle();
    tests_run++; if (slv_addr !== m0_addr || m0_req_ack !== 1'b0 || slv_req !== 1'b1) begin tests_failed++;
      $display("[TB] FAIL areset_first_tie: got addr %h ack %b req %b expected %h 0 1", slv_addr, m0_req_ack, slv_req, m0_addr); end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    bit busy, drain, win, fire, ereq, eack0, eack1, acc;
    int owner, last, waited, g, r;
    logic [1:0] oresp, e0r, e1r;
    logic [31:0] odata, e0d, e1d, eaddr;
    do_reset();
    busy = 0; drain = 0; owner = 0; last = 1; waited = 0;
    for (int c = 0; c < 800; c++) begin
      m0_req = ($urandom_range(0, 2) != 0); m1_req = ($urandom_range(0, 2) != 0);
      m0_cmd = 1'($urandom_range(0, 1)); m1_cmd = 1'($urandom_range(0, 1));
      m0_addr = $urandom; m1_addr = $urandom; m0_wdata = $urandom; m1_wdata = $urandom;
      slv_req_ack = ($urandom_range(0, 3) != 0); slv_rdata = $urandom;
      r = $urandom_range(0, 9);
      slv_resp = (r < 5) ? SCR1_MEM_RESP_NOTRDY : (r < 9) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_RDY_ER;
      settle();
      // Reference: who would win, is the port free, and what the waiting owner should see.
      if (m0_req && m1_req) g = 1 - last; else if (m1_req) g = 1; else g = 0;
      fire  = busy && slv_resp == SCR1_MEM_RESP_NOTRDY && waited == TO;
      win   = (!busy && !drain) || (busy && slv_resp == SCR1_MEM_RESP_RDY_OK);
      ereq  = win && (g == 1 ? m1_req : m0_req);
      eack0 = win && slv_req_ack && g == 0;
      eack1 = win && slv_req_ack && g == 1;
      eaddr = (g == 1) ? m1_addr : m0_addr;
      oresp = fire ? SCR1_MEM_RESP_RDY_ER : slv_resp;
      odata = fire ? 32'h0 : slv_rdata;
      e0r = (busy && owner == 0) ? oresp : SCR1_MEM_RESP_NOTRDY;
      e0d = (busy && owner == 0) ? odata : 32'h0;
      e1r = (busy && owner == 1) ? oresp : SCR1_MEM_RESP_NOTRDY;
      e1d = (busy && owner == 1) ? odata : 32'h0;
      tests_run++; if (slv_req !== ereq || slv_addr !== eaddr) begin tests_failed++;
        $display("[TB] FAIL rand_slv_%0d: got req %b addr %h expected %b %h", c, slv_req, slv_addr, ereq, eaddr); end
      tests_run++; if (m0_req_ack !== eack0 || m1_req_ack !== eack1) begin tests_failed++;
        $display("[TB] FAIL rand_ack_%0d: got %b%b expected %b%b", c, m0_req_ack, m1_req_ack, eack0, eack1); end
      tests_run++; if (m0_resp !== e0r || m0_rdata !== e0d) begin tests_failed++;
        $display("[TB] FAIL rand_m0_%0d: got %0d %h expected %0d %h", c, m0_resp, m0_rdata, e0r, e0d); end
      tests_run++; if (m1_resp !== e1r || m1_rdata !== e1d) begin tests_failed++;
        $display("[TB] FAIL rand_m1_%0d: got %0d %h expected %0d %h", c, m1_resp, m1_rdata, e1r, e1d); end
      tests_run++; if (timeout_o !== fire) begin tests_failed++;
        $display("[TB] FAIL rand_timeout_%0d: got %b expected %b", c, timeout_o, fire); end
      acc = ereq && slv_req_ack;
      if (drain) begin
        if (slv_resp != SCR1_MEM_RESP_NOTRDY) drain = 0;
      end else if (busy && slv_resp == SCR1_MEM_RESP_NOTRDY) begin
        if (fire) begin busy = 0; drain = 1; end
        else waited++;
      end else if (busy && !acc) begin
        busy = 0;
      end else if (acc) begin
        busy = 1; owner = g; last = g; waited = 0;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_pipeline();
    test_error();
    test_timeout();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/scr1_mem_arbiter.md
# scr1_mem_arbiter

Two-master to one-slave arbiter for the SCR1 data-memory interface (req/req_ack address phase, resp/rdata data phase). It shares a single memory port, typically a router port such as TCM or external bus, between the core data port (M0) and a second master such as debug or DMA (M1). Arbitration is round-robin. At most one transaction is outstanding, with back-to-back pipelined issue, and a response-timeout watchdog is included. Response routing adds no latency; all paths are combinational passthroughs, steered by registered owner state.

## Interface
- `TIMEOUT_CYC`, default 255: cycles of `SCR1_MEM_RESP_NOTRDY` tolerated after acceptance before an error is forced; 0 disables the watchdog.
- `TIMEOUT_W`, default 8: width of the watchdog counter; must satisfy TIMEOUT_CYC < 2^TIMEOUT_W.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `m0_req`  in  1  M0 request.
- `m0_req_ack`  out  1  M0 request accepted.
- `m0_cmd`  in  1  M0 command (read/write).
- `m0_width`  in  type_scr1_mem_width_e  M0 access width.
- `m0_addr`  in  `SCR1_DMEM_AWIDTH`  M0 address.
- `m0_wdata`  in  `SCR1_DMEM_DWIDTH`  M0 write data.
- `m0_rdata`  out  `SCR1_DMEM_DWIDTH`  M0 read data.
- `m0_resp`  out  2  M0 response.
- `m1_*`  same set as `m0_*`, for M1.
- `slv_req`  out  1  slave request.
- `slv_req_ack`  in  1  slave acceptance.
- `slv_cmd`  out  1  slave command, muxed from the granted master.
- `slv_width`  out  type_scr1_mem_width_e  slave width, muxed.
- `slv_addr`  out  `SCR1_DMEM_AWIDTH`  slave address, muxed.
- `slv_wdata`  out  `SCR1_DMEM_DWIDTH`  slave write data, muxed.
- `slv_rdata`  in  `SCR1_DMEM_DWIDTH`  slave read data.
- `slv_resp`  in  2  slave response.
- `timeout_o`  out  1  one-cycle pulse when the watchdog fires.

## Operation
- State machine has three states: IDLE, DATA and DRAIN. Registers:
  - `owner_r`: master of the outstanding transaction.
  - `last_r`: last master granted.
  - `cnt_r`: watchdog counter.
- Grant (combinational):
  - Only one master requesting: that master.
  - Both requesting: the master that is not `last_r`.
  - Neither requesting: M0.
- Issue window is open in IDLE, or in DATA when `slv_resp == SCR1_MEM_RESP_RDY_OK`. It is closed in every other case.
- Address-phase signals:
  - `slv_req` equals the granted master's req while the window is open, else 0.
  - `slv_cmd`, `slv_width`, `slv_addr` and `slv_wdata` always follow the grant.
- Request acknowledge:
  - Granted master: `mX_req_ack = window & slv_req_ack`.
  - Non-granted master: `mX_req_ack = 0`.
- Acceptance (`slv_req & slv_req_ack`) updates, on the next edge:
  - `owner_r`, `last_r` <= grant
  - `cnt_r` <= 0
  - state <= DATA
- DATA state:
  - Response routing: `slv_resp` and `slv_rdata` go to `owner_r`. The other master sees resp NOTRDY and rdata 0.
  - RDY_OK with no new acceptance: go to IDLE.
  - RDY_OK with a new acceptance: stay in DATA with the new owner (pipelined).
  - RDY_ER: go to IDLE. No issue is allowed in the same cycle.
  - NOTRDY: `cnt_r` increments.
- Watchdog, when `TIMEOUT_CYC != 0` and `cnt_r == TIMEOUT_CYC` while in DATA with NOTRDY:
  - Owner sees `SCR1_MEM_RESP_RDY_ER` and rdata 0 that cycle.
  - `timeout_o` = 1.
  - State goes to DRAIN.
- DRAIN state:
  - Window is closed. Both masters see NOTRDY.
  - The first non-NOTRDY `slv_resp` is swallowed; state goes to IDLE.
  - The counter does not run.
- Reset values:
  - state = IDLE, `last_r` = M1 (so M0 wins the first tie), `owner_r` = M0, `cnt_r` = 0.
  - All req_ack = 0, all `mX_resp` = NOTRDY, all `mX_rdata` = 0, `slv_req` = 0 (with no requests), `timeout_o` = 0.
- Reset asserted mid-transaction: state is discarded. The slave's late response after reset is ignored, because the arbiter is in IDLE and routes nothing.

## Timing
- req_ack path is combinational: `slv_req_ack` to `mX_req_ack`, with zero added latency.
- Response path is combinational: `slv_resp`/`slv_rdata` to `mX_resp`/`mX_rdata`, with zero added latency.
- Grant is stable within a cycle; `last_r` changes only on acceptance.
- A master holding req with `slv_req_ack = 0` keeps its grant until accepted, unless the other master becomes the round-robin winner. Round-robin is evaluated every cycle.
- Timeout fires in the cycle where `cnt_r` reaches `TIMEOUT_CYC`, i.e. the (TIMEOUT_CYC+1)-th NOTRDY cycle after acceptance.
- Back-to-back throughput is 1 transaction/cycle with a single-cycle slave.

## Test plan
- **Single master.** M0 read of 0x0001_0010, slave ack=1, RDY_OK with 0xDEADBEEF on the next cycle. Required: `m0_req_ack` in cycle 0; `m0_resp` = RDY_OK and `m0_rdata` = 0xDEADBEEF in cycle 1; M1 sees NOTRDY and rdata 0.
- **Contention.** Both masters request continuously for 4 cycles with an always-ready slave. Required: grants go M0, M1, M0, M1; each response is routed to the correct owner.
- **Pipelining.** M1 write accepted, then RDY_OK arrives while M0 requests. Required: M0 accepted in the same cycle; state stays DATA; `owner_r` = M0.
- **Error.** Slave returns RDY_ER while M1 is requesting. Required: `m1_req_ack` = 0 that cycle; M1 is accepted the next cycle from IDLE.
- **Timeout.** TIMEOUT_CYC=3, slave never responds after acceptance. Required: owner sees RDY_ER and `timeout_o` = 1 on the 4th NOTRDY cycle. The late RDY_OK that follows is swallowed; the next request is accepted after it.
- **Reset.** Assert `rst` asynchronously mid-DATA. Required: outputs immediately return to reset values; the post-reset slave response is ignored.
